// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the packet-aware round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Widest request vector rr_pick can handle; arbiters must keep N <= MAX_N.
    localparam int MAX_N     = 32;
    localparam int N_DEFAULT = 4;
    localparam int SRC_BITS  = $clog2(N_DEFAULT);

    // Cyclic priority encoder: first set bit of req[n-1:0] found by walking
    // upward from ptr and wrapping past n-1 back to 0. Returns ptr when no
    // bit is set; callers only use the result when at least one bit is set.
    function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = ptr;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (req[idx[$clog2(MAX_N)-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_fifo.sv
// Small ready/valid FIFO. Its input ready depends only on its own occupancy
// register, which is what breaks the ordy -> irdy combinational path.
module stream_rr_arbiter_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ivld,
    output logic             irdy,
    input  logic [WIDTH-1:0] idat,
    output logic             ovld,
    input  logic             ordy,
    output logic [WIDTH-1:0] odat
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign irdy = (count != CW'(DEPTH));
    assign ovld = (count != '0);
    assign odat = mem[rptr];
    assign push = ivld && irdy;
    assign pop  = ovld && ordy;

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= bump(wptr);
            if (pop)  rptr <= bump(rptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= idat;
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: merges N ready/valid inputs into one
// output stream, holding a grant for a whole packet or MAX_BURST beats, and
// tagging every beat with the index of the input it came from.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         ivld,
    output logic [N-1:0]         irdy,
    input  logic [N*WIDTH-1:0]   idat,
    input  logic [N-1:0]         ilast,
    output logic                 ovld,
    input  logic                 ordy,
    output logic [WIDTH-1:0]     odat,
    output logic                 olast,
    output logic [$clog2(N)-1:0] osrc
);

    localparam int SRC_W = $clog2(N);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam int STG_W = WIDTH + 1 + SRC_W;
    localparam logic [CNT_W-1:0] CNT_LAST = (MAX_BURST > 0) ? CNT_W'(MAX_BURST - 1) : '0;

    state_t           state;
    logic [SRC_W-1:0] ptr;
    logic [SRC_W-1:0] grant;
    logic [CNT_W-1:0] cnt;

    logic             stage_irdy;
    logic             in_vld;
    logic [WIDTH-1:0] in_dat;
    logic             in_last;
    logic             accept;
    logic             cut;
    logic             end_beat;
    logic [STG_W-1:0] stage_in;
    logic [STG_W-1:0] stage_out;

    assign in_dat   = idat[grant*WIDTH +: WIDTH];
    assign in_last  = ilast[grant];
    assign in_vld   = (state == LOCK) && ivld[grant];
    assign accept   = in_vld && stage_irdy;
    assign cut      = (MAX_BURST > 0) && (cnt == CNT_LAST);
    assign end_beat = accept && (in_last || cut);
    assign stage_in = {in_last | cut, grant, in_dat};

    // Only the locked input sees the output stage's ready; all others wait.
    always_comb begin
        irdy = '0;
        if (state == LOCK) irdy[grant] = stage_irdy;
    end

    // Arbitration FSM: pick a requester in IDLE, stream its beats in LOCK
    // until the packet ends or the burst limit forces a cut.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (|ivld) begin
                        grant <= SRC_W'(rr_pick(MAX_N'(ivld), int'(ptr), N));
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if (end_beat) begin
                        ptr   <= (grant == SRC_W'(N - 1)) ? '0 : grant + SRC_W'(1);
                        state <= IDLE;
                    end else if (accept) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    stream_rr_arbiter_fifo #(
        .DEPTH (2),
        .WIDTH (STG_W)
    ) u_stage (
        .clk  (clk),
        .rst  (rst),
        .ivld (in_vld),
        .irdy (stage_irdy),
        .idat (stage_in),
        .ovld (ovld),
        .ordy (ordy),
        .odat (stage_out)
    );

    assign {olast, osrc, odat} = stage_out;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (N=4, WIDTH=32, MAX_BURST=4).
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   ivld;
    logic [N-1:0]   irdy;
    logic [N*W-1:0] idat;
    logic [N-1:0]   ilast;
    logic           ovld;
    logic           ordy;
    logic [W-1:0]   odat;
    logic           olast;
    logic [1:0]     osrc;

    stream_rr_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .ivld(ivld), .irdy(irdy), .idat(idat), .ilast(ilast),
        .ovld(ovld), .ordy(ordy), .odat(odat), .olast(olast), .osrc(osrc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] data; logic last; } src_beat_t;
    typedef struct { logic [W-1:0] data; logic last; int src; int cyc; } out_beat_t;

    src_beat_t src_q [N][$];
    bit        presented [N];
    out_beat_t dut_log [$];

    // Reference model: packet-level view of the arbiter with a 2-entry queue
    out_beat_t m_fifo [$];
    bit        m_busy;
    int        m_ptr, m_grant, m_beats;

    int checks, failures, cyc;
    bit rand_valid, rand_ready, ordy_level;

    function automatic logic [N-1:0] m_irdy_f();
        if (m_busy && m_fifo.size() < 2) return N'(1) << m_grant;
        return '0;
    endfunction

    task automatic load_packet(input int s, input int len, input logic [W-1:0] base);
        src_beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + W'(k);
            b.last = (k == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            presented[i] = 0;
        end
        dut_log.delete();
    endtask

    // One clock cycle: drive inputs, log DUT output transfers, step the model
    task automatic advance(input bit rst_in);
        logic [N-1:0] acc, mi;
        out_beat_t    ob, nb;
        bit           m_pop, found, endb;
        rst = rst_in;
        for (int i = 0; i < N; i++) begin
            if (!presented[i] && src_q[i].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0))
                presented[i] = 1;
            ivld[i]        = presented[i];
            idat[i*W +: W] = presented[i] ? src_q[i][0].data : '0;
            ilast[i]       = presented[i] ? src_q[i][0].last : 1'b0;
        end
        ordy = rand_ready ? ($urandom_range(0, 2) != 0) : ordy_level;
        if (!rst_in && ovld && ordy) begin
            ob.data = odat; ob.last = olast; ob.src = int'(osrc); ob.cyc = cyc;
            dut_log.push_back(ob);
        end
        acc = rst_in ? '0 : (ivld & irdy);
        mi  = m_irdy_f();
        if (rst_in) begin
            m_fifo.delete(); m_busy = 0; m_ptr = 0; m_grant = 0; m_beats = 0;
        end else begin
            m_pop  = (m_fifo.size() > 0) && ordy;
            nb.src = -1;
            if (!m_busy) begin
                found = 0;
                for (int k = 0; k < N; k++)
                    if (!found && ivld[(m_ptr + k) % N]) begin
                        m_grant = (m_ptr + k) % N; found = 1;
                    end
                if (found) begin m_busy = 1; m_beats = 0; end
            end else if (ivld[m_grant] && mi[m_grant]) begin
                m_beats++;
                endb    = ilast[m_grant] || (MB > 0 && m_beats == MB);
                nb.data = idat[m_grant*W +: W]; nb.last = endb; nb.src = m_grant; nb.cyc = 0;
                if (endb) begin m_busy = 0; m_ptr = (m_grant + 1) % N; end
            end
            if (m_pop) void'(m_fifo.pop_front());
            if (nb.src >= 0) m_fifo.push_back(nb);
        end
        for (int i = 0; i < N; i++)
            if (acc[i]) begin void'(src_q[i].pop_front()); presented[i] = 0; end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic reset_all();
        advance(1);
        clear_all();
    endtask

    task automatic test_reset();
        advance(1);
        advance(1);
        checks++; if (irdy !== '0)   begin failures++; $display("[TB] FAIL reset_irdy actual=%b required=%b", irdy, 4'b0); end
        checks++; if (ovld !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovld actual=%b required=0", ovld); end
        advance(0);
        checks++; if (irdy !== '0)   begin failures++; $display("[TB] FAIL idle_irdy actual=%b required=%b", irdy, 4'b0); end
        dut_log.delete();
    endtask

    task automatic test_single_source();
        int c0;
        reset_all();
        rand_valid = 0; rand_ready = 0; ordy_level = 1;
        load_packet(2, 4, 32'h0000_0200);
        c0 = cyc;
        for (int c = 0; c < 40 && dut_log.size() < 4; c++) advance(0);
        checks++; if (dut_log.size() != 4) begin failures++; $display("[TB] FAIL single_count actual=%0d required=4", dut_log.size()); end
        if (dut_log.size() > 0) begin
            checks++; if (dut_log[0].cyc != c0 + 2) begin failures++; $display("[TB] FAIL single_latency actual=%0d required=%0d", dut_log[0].cyc - c0, 2); end
        end
        for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
            checks++; if (dut_log[k].src != 2) begin failures++; $display("[TB] FAIL single_src beat=%0d actual=%0d required=2", k, dut_log[k].src); end
            checks++; if (dut_log[k].data !== 32'h200 + W'(k)) begin failures++; $display("[TB] FAIL single_data beat=%0d actual=%h required=%h", k, dut_log[k].data, 32'h200 + W'(k)); end
            checks++; if (dut_log[k].last !== (k == 3)) begin failures++; $display("[TB] FAIL single_last beat=%0d actual=%b required=%b", k, dut_log[k].last, k == 3); end
        end
    endtask

    task automatic test_all_inputs();
        int exp_src [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [W-1:0] exp_d;
        int exp_gap;
        reset_all();
        for (int s = 0; s < N; s++) load_packet(s, 2, W'(32'h1000 * (s + 1)));
        load_packet(0, 2, 32'h1010);
        for (int c = 0; c < 80 && dut_log.size() < 10; c++) advance(0);
        checks++; if (dut_log.size() != 10) begin failures++; $display("[TB] FAIL all_count actual=%0d required=10", dut_log.size()); end
        for (int k = 0; k < 10 && k < dut_log.size(); k++) begin
            exp_d = W'(32'h1000 * (exp_src[k] + 1) + ((k >= 8) ? 16 : 0) + (k % 2));
            checks++; if (dut_log[k].src != exp_src[k]) begin failures++; $display("[TB] FAIL all_order beat=%0d actual=%0d required=%0d", k, dut_log[k].src, exp_src[k]); end
            checks++; if (dut_log[k].data !== exp_d) begin failures++; $display("[TB] FAIL all_data beat=%0d actual=%h required=%h", k, dut_log[k].data, exp_d); end
            if (k > 0) begin
                exp_gap = (k % 2 == 0) ? 2 : 1;
                checks++; if (dut_log[k].cyc - dut_log[k-1].cyc != exp_gap) begin failures++; $display("[TB] FAIL all_gap beat=%0d actual=%0d required=%0d", k, dut_log[k].cyc - dut_log[k-1].cyc, exp_gap); end
            end
        end
    endtask

    task automatic test_ptr_wrap();
        int exp_src [6] = '{2, 2, 3, 3, 0, 0};
        reset_all();
        load_packet(2, 2, 32'h2300);
        for (int c = 0; c < 30 && dut_log.size() < 2; c++) advance(0);
        load_packet(0, 2, 32'h0300);
        load_packet(3, 2, 32'h3300);
        for (int c = 0; c < 40 && dut_log.size() < 6; c++) advance(0);
        checks++; if (dut_log.size() != 6) begin failures++; $display("[TB] FAIL wrap_count actual=%0d required=6", dut_log.size()); end
        for (int k = 0; k < 6 && k < dut_log.size(); k++) begin
            checks++; if (dut_log[k].src != exp_src[k]) begin failures++; $display("[TB] FAIL wrap_order beat=%0d actual=%0d required=%0d", k, dut_log[k].src, exp_src[k]); end
        end
    endtask

    task automatic test_burst_cut();
        int           exp_src [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [W-1:0] exp_d   [14] = '{32'h0100, 32'h0101, 32'h1100, 32'h1101, 32'h1102, 32'h1103, 32'h0110,
                                       32'h0111, 32'h1104, 32'h1105, 32'h1106, 32'h1107, 32'h1108, 32'h1109};
        bit           exp_l   [14] = '{0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 1};
        reset_all();
        load_packet(1, 10, 32'h1100);
        load_packet(0, 2, 32'h0100);
        load_packet(0, 2, 32'h0110);
        for (int c = 0; c < 80 && dut_log.size() < 14; c++) advance(0);
        checks++; if (dut_log.size() != 14) begin failures++; $display("[TB] FAIL cut_count actual=%0d required=14", dut_log.size()); end
        for (int k = 0; k < 14 && k < dut_log.size(); k++) begin
            checks++;
            if (dut_log[k].src != exp_src[k] || dut_log[k].data !== exp_d[k] || dut_log[k].last !== exp_l[k]) begin
                failures++;
                $display("[TB] FAIL cut_beat beat=%0d actual=src%0d/%h/last%b required=src%0d/%h/last%b",
                         k, dut_log[k].src, dut_log[k].data, dut_log[k].last, exp_src[k], exp_d[k], exp_l[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        int stall_left = -1;
        logic [N-1:0] exp_irdy;
        reset_all();
        load_packet(1, 4, 32'h5100);
        for (int c = 0; c < 60 && dut_log.size() < 4; c++) begin
            if (dut_log.size() == 1 && stall_left < 0) stall_left = 5;
            ordy_level = !(stall_left > 0);
            advance(0);
            exp_irdy = m_irdy_f();
            checks++; if (irdy !== exp_irdy) begin failures++; $display("[TB] FAIL bp_irdy cyc=%0d actual=%b required=%b", cyc, irdy, exp_irdy); end
            checks++; if (ovld !== (m_fifo.size() > 0)) begin failures++; $display("[TB] FAIL bp_ovld cyc=%0d actual=%b required=%b", cyc, ovld, m_fifo.size() > 0); end
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    checks++; if (ovld !== 1'b1 || irdy !== '0) begin failures++; $display("[TB] FAIL bp_full actual=ovld%b/irdy%b required=ovld1/irdy0000", ovld, irdy); end
                end
            end
        end
        ordy_level = 1;
        checks++; if (dut_log.size() != 4) begin failures++; $display("[TB] FAIL bp_count actual=%0d required=4", dut_log.size()); end
        for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
            checks++; if (dut_log[k].data !== 32'h5100 + W'(k) || dut_log[k].last !== (k == 3)) begin
                failures++; $display("[TB] FAIL bp_beat beat=%0d actual=%h/%b required=%h/%b", k, dut_log[k].data, dut_log[k].last, 32'h5100 + W'(k), k == 3);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int exp_src [4] = '{1, 1, 3, 3};
        reset_all();
        load_packet(2, 2, 32'h2700);
        for (int c = 0; c < 30 && dut_log.size() < 2; c++) advance(0);
        load_packet(3, 4, 32'h3600);
        advance(0); advance(0); advance(0);
        advance(1);
        checks++; if (ovld !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ovld actual=%b required=0", ovld); end
        checks++; if (irdy !== '0)   begin failures++; $display("[TB] FAIL rstmid_irdy actual=%b required=%b", irdy, 4'b0); end
        clear_all();
        load_packet(3, 2, 32'h3700);
        load_packet(1, 2, 32'h1700);
        advance(0);
        checks++; if (irdy !== 4'b0010) begin failures++; $display("[TB] FAIL rstmid_grant actual=%b required=%b", irdy, 4'b0010); end
        for (int c = 0; c < 40 && dut_log.size() < 4; c++) advance(0);
        checks++; if (dut_log.size() != 4) begin failures++; $display("[TB] FAIL rstmid_count actual=%0d required=4", dut_log.size()); end
        for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
            checks++; if (dut_log[k].src != exp_src[k]) begin failures++; $display("[TB] FAIL rstmid_order beat=%0d actual=%0d required=%0d", k, dut_log[k].src, exp_src[k]); end
        end
    endtask

    task automatic test_random();
        int total = 0;
        int s, len;
        bit pending;
        logic [N-1:0] exp_irdy;
        reset_all();
        rand_valid = 1; rand_ready = 1;
        for (int c = 0; c < 1200; c++) begin
            if (c < 700 && $urandom_range(0, 7) == 0) begin
                s = $urandom_range(0, N - 1);
                if (src_q[s].size() < 8) begin
                    len = $urandom_range(1, 6);
                    load_packet(s, len, $urandom());
                    total += len;
                end
            end
            advance(0);
            exp_irdy = m_irdy_f();
            checks++; if (irdy !== exp_irdy) begin failures++; $display("[TB] FAIL rnd_irdy cyc=%0d actual=%b required=%b", cyc, irdy, exp_irdy); end
            checks++; if (ovld !== (m_fifo.size() > 0)) begin failures++; $display("[TB] FAIL rnd_ovld cyc=%0d actual=%b required=%b", cyc, ovld, m_fifo.size() > 0); end
            if (m_fifo.size() > 0) begin
                checks++;
                if ({olast, osrc, odat} !== {m_fifo[0].last, 2'(m_fifo[0].src), m_fifo[0].data}) begin
                    failures++;
                    $display("[TB] FAIL rnd_beat cyc=%0d actual=src%0d/%h/last%b required=src%0d/%h/last%b",
                             cyc, osrc, odat, olast, m_fifo[0].src, m_fifo[0].data, m_fifo[0].last);
                end
            end
            pending = (m_fifo.size() > 0) || ovld;
            for (int i = 0; i < N; i++) if (src_q[i].size() > 0) pending = 1;
            if (c >= 700 && !pending) break;
        end
        rand_valid = 0; rand_ready = 0;
        checks++; if (dut_log.size() != total) begin failures++; $display("[TB] FAIL rnd_total actual=%0d required=%0d", dut_log.size(), total); end
    endtask

    initial begin
        rst = 1'b1; ivld = '0; idat = '0; ilast = '0; ordy = 1'b1;
        checks = 0; failures = 0; cyc = 0;
        rand_valid = 0; rand_ready = 0; ordy_level = 1;
        m_busy = 0; m_ptr = 0; m_grant = 0; m_beats = 0;
        @(negedge clk);
        test_reset();
        test_single_source();
        test_all_inputs();
        test_ptr_wrap();
        test_burst_cut();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
